hack_mem_arbiter: RTL and testbench

Shares the single data RAM between the Hack CPU and a read-only DMA engine that streams a block of RAM words out over a valid/ready interface. The block is intended for screen refresh or host readback. The CPU has no stall input, so it always wins: it gets every cycle in which its current instruction touches M, and the DMA engine fills only the idle cycles. The block sits between the CPU memory port, the RAM, and a downstream consumer such as a video serializer.

---
 rtl/hack_pkg.sv | 18 +
 rtl/hack_sync_fifo.sv | 51 +++++
 rtl/hack_mem_arbiter.sv | 105 ++++++++++
 tb/tb_hack_mem_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack memory arbiter and its helpers.
package hack_pkg;
  typedef logic [15:0] word_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} dma_state_t;

  localparam int I_CINSTR = 15;
  localparam int I_ABIT   = 12;
  localparam int I_DEST_M = 3;

  localparam word_t SCREEN_BASE  = 16'h4000;
  localparam int    SCREEN_WORDS = 8192;
  localparam word_t KBD_ADDR     = 16'h6000;

  // A C-instruction touches M when it reads M (a=1) or writes M (dest M).
  function automatic logic uses_m(input word_t instr);
    return instr[I_CINSTR] & (instr[I_ABIT] | instr[I_DEST_M]);
  endfunction
endpackage

// File: rtl/hack_sync_fifo.sv
// Synchronous first-word fall-through FIFO; head word is read straight from storage.
module hack_sync_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rptr, r_wptr;
  logic [CW-1:0] r_count;
  logic          w_pop, w_push;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rptr];
  assign w_pop  = pop & ~empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/hack_mem_arbiter.sv
// Shares the Hack data RAM between the CPU (always wins) and a read-only DMA
// streamer that fills idle RAM cycles and hands words out via a small FIFO.
module hack_mem_arbiter
  import hack_pkg::*;
#(
  parameter int AW    = 15,
  parameter int LEN_W = 14,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      cpu_instr,
  input  logic [15:0]      cpu_addr,
  input  logic [15:0]      cpu_wdata,
  input  logic             cpu_write,
  output logic [15:0]      cpu_rdata,
  output logic [AW-1:0]    ram_addr,
  output logic [15:0]      ram_wdata,
  output logic             ram_we,
  input  logic [15:0]      ram_rdata,
  input  logic             dma_start,
  input  logic [AW-1:0]    dma_base,
  input  logic [LEN_W-1:0] dma_len,
  output logic             dma_busy,
  output logic             dma_done,
  output logic [15:0]      stream_data,
  output logic             stream_valid,
  input  logic             stream_ready
);
  localparam int CW = $clog2(DEPTH + 1);

  dma_state_t       r_state, w_next;
  logic [AW-1:0]    r_ptr;
  logic [LEN_W-1:0] r_rem;
  logic             r_done, w_done_nxt;
  logic             w_cpu_mem, w_pop, w_issue, w_full, w_empty;
  logic [CW-1:0]    w_count;
  logic             w_unused;

  assign w_unused  = &{1'b0, cpu_addr[15:AW]};
  assign w_cpu_mem = uses_m(cpu_instr);
  assign w_pop     = stream_valid & stream_ready;
  assign w_issue   = (r_state == RUN) & ~w_cpu_mem & (~w_full | w_pop) & (r_rem != '0);

  assign ram_wdata    = cpu_wdata;
  assign cpu_rdata    = ram_rdata;
  assign stream_valid = ~w_empty;
  assign dma_busy     = (r_state != IDLE);
  assign dma_done     = r_done;

  always_comb begin
    ram_addr = cpu_addr[AW-1:0];
    ram_we   = 1'b0;
    if (w_cpu_mem)    ram_we   = cpu_write;
    else if (w_issue) ram_addr = r_ptr;
  end

  always_comb begin
    w_next     = r_state;
    w_done_nxt = 1'b0;
    case (r_state)
      IDLE: if (dma_start) begin
        if (dma_len != '0) w_next     = RUN;
        else               w_done_nxt = 1'b1;
      end
      RUN:  if (w_issue && r_rem == LEN_W'(1)) w_next = DRAIN;
      DRAIN: if (w_count == '0) begin
        w_next     = IDLE;
        w_done_nxt = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
      r_ptr   <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_nxt;
      if (r_state == IDLE && dma_start && dma_len != '0) begin
        r_ptr <= dma_base;
        r_rem <= dma_len;
      end else if (w_issue) begin
        r_ptr <= r_ptr + AW'(1);
        r_rem <= r_rem - LEN_W'(1);
      end
    end
  end

  hack_sync_fifo #(.W(16), .DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_issue),
    .din   (ram_rdata),
    .pop   (w_pop),
    .dout  (stream_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );
endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Scoreboard bench: expected stream words and DMA addresses are queued at start
// and retired as the DUT reads RAM and hands words to the consumer.
module tb_hack_mem_arbiter;
  import hack_pkg::*;
  localparam int AW = 15, LEN_W = 14, DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] cpu_instr, cpu_addr, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata, stream_data;
  logic cpu_write, ram_we, dma_start, dma_busy, dma_done, stream_valid, stream_ready;
  logic [AW-1:0] ram_addr, dma_base;
  logic [LEN_W-1:0] dma_len;

  always #5 clk = ~clk;

  hack_mem_arbiter #(.AW(AW), .LEN_W(LEN_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cpu_instr(cpu_instr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .dma_start(dma_start), .dma_base(dma_base), .dma_len(dma_len),
    .dma_busy(dma_busy), .dma_done(dma_done), .stream_data(stream_data),
    .stream_valid(stream_valid), .stream_ready(stream_ready)
  );

  word_t ram [0:32767];
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  word_t exp_data[$];
  logic [AW-1:0] exp_addr[$];
  int n_rd = 0, n_done = 0, cyc = 0, first_pop = -1, last_pop = -1;
  int mode = 0;
  logic tog = 1'b0;

  // CPU driver: 0 = A-instructions only, 1 = D=M / A alternating, 2 = M=D / A alternating.
  always @(posedge clk) begin
    #1;
    tog = ~tog;
    cpu_instr = 16'h0123; cpu_addr = 16'h0123; cpu_wdata = 16'h0000; cpu_write = 1'b0;
    if (mode == 1 && tog) begin
      cpu_instr = 16'hFC10; cpu_addr = 16'h0005;
    end else if (mode == 2 && tog) begin
      cpu_instr = 16'hE308; cpu_addr = 16'h0010; cpu_wdata = 16'hBEEF; cpu_write = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      cyc++;
      if (cpu_instr[15] & (cpu_instr[12] | cpu_instr[3])) begin
        check("cpu_addr", 32'(ram_addr), 32'(cpu_addr[AW-1:0]));
        check("cpu_we", 32'(ram_we), 32'(cpu_write));
        if (!cpu_write) check("cpu_rd", 32'(cpu_rdata), 32'h5555);
      end else if (ram_addr != cpu_addr[AW-1:0]) begin
        n_rd++;
        check("dma_we", 32'(ram_we), 32'd0);
        if (exp_addr.size() != 0) check("dma_addr", 32'(ram_addr), 32'(exp_addr.pop_front()));
        else check("dma_extra_rd", 32'(exp_addr.size()), 32'd1);
      end
      if (stream_valid && stream_ready) begin
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        if (exp_data.size() != 0) check("stream", 32'(stream_data), 32'(exp_data.pop_front()));
        else check("stream_extra", 32'(exp_data.size()), 32'd1);
      end
      if (dma_done) begin
        n_done++;
        check("done_busy", 32'(dma_busy), 32'd0);
      end
    end
  end

  task automatic start_xfer(input int base, input int len);
    @(posedge clk); #2;
    dma_base = AW'(base); dma_len = LEN_W'(len); dma_start = 1'b1;
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(AW'(base + i));
      exp_data.push_back(ram[(base + i) & 32'h7FFF]);
    end
    @(posedge clk); #2;
    dma_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int t = 0;
    while (n_done == d0 && t < 300) begin @(negedge clk); t++; end
    repeat (4) @(negedge clk);
    check({tag, "_done_once"}, 32'(n_done), 32'(d0 + 1));
    check({tag, "_busy"}, 32'(dma_busy), 32'd0);
    check({tag, "_left"}, 32'(exp_data.size() + exp_addr.size()), 32'd0);
  endtask

  initial begin
    int d0, rd0, t;
    reset = 1'b1; dma_start = 1'b0; dma_base = '0; dma_len = '0; stream_ready = 1'b1;
    cpu_instr = 16'h0123; cpu_addr = 16'h0123; cpu_wdata = '0; cpu_write = 1'b0;
    for (int i = 0; i < 32768; i++) ram[i] = 16'(i ^ 16'h3C00);
    for (int i = 0; i < 4; i++) ram[16'h4000 + i] = 16'(i + 1);
    for (int i = 0; i < 6; i++) ram[16'h4100 + i] = 16'(16'hA0 + i);
    ram[5] = 16'h5555; ram[16'h7FFF] = 16'h7777; ram[0] = 16'h0F0F;
    #1;
    check("rst_busy", 32'(dma_busy), 32'd0);
    check("rst_done", 32'(dma_done), 32'd0);
    check("rst_valid", 32'(stream_valid), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Idle CPU, back-to-back stream.
    first_pop = -1; d0 = n_done;
    start_xfer(16'h4000, 4);
    wait_done("t1", d0);
    check("t1_consec", 32'(last_pop - first_pop), 32'd3);

    // CPU alternates D=M with A-instructions.
    mode = 1; d0 = n_done;
    start_xfer(16'h4000, 4);
    wait_done("t2", d0);

    // CPU writes M while the DMA runs.
    mode = 2; d0 = n_done;
    start_xfer(16'h4100, 6);
    wait_done("t3", d0);
    mode = 0;
    repeat (2) @(negedge clk);
    check("t3_ram_wr", 32'(ram[16'h0010]), 32'hBEEF);

    // Back-pressure: FIFO fills to DEPTH and the DMA stops reading.
    stream_ready = 1'b0; d0 = n_done; rd0 = n_rd;
    start_xfer(16'h4100, 6);
    repeat (20) @(negedge clk);
    check("stall_rd", 32'(n_rd - rd0), 32'(DEPTH));
    check("stall_head", 32'(stream_data), 32'h00A0);
    check("stall_busy", 32'(dma_busy), 32'd1);
    stream_ready = 1'b1;
    wait_done("t4", d0);
    check("t4_rd", 32'(n_rd - rd0), 32'd6);

    // Address wrap.
    d0 = n_done;
    start_xfer(16'h7FFF, 2);
    wait_done("wrap", d0);

    // Zero-length transfer.
    d0 = n_done; rd0 = n_rd;
    @(posedge clk); #2;
    dma_len = '0; dma_base = AW'(16'h4000); dma_start = 1'b1;
    @(posedge clk); #2;
    dma_start = 1'b0;
    @(negedge clk);
    check("len0_done", 32'(dma_done), 32'd1);
    check("len0_busy", 32'(dma_busy), 32'd0);
    repeat (4) @(negedge clk);
    check("len0_rd", 32'(n_rd - rd0), 32'd0);
    check("len0_once", 32'(n_done), 32'(d0 + 1));

    // Asynchronous reset mid-transfer with words buffered.
    stream_ready = 1'b0; rd0 = n_rd; t = 0;
    start_xfer(16'h4000, 4);
    while (n_rd - rd0 < 2 && t < 100) begin @(negedge clk); t++; end
    check("rst_mid_rd", 32'(n_rd - rd0 >= 2), 32'd1);
    @(posedge clk); #2;
    check("pre_rst_valid", 32'(stream_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(stream_valid), 32'd0);
    check("mid_rst_busy", 32'(dma_busy), 32'd0);
    check("mid_rst_done", 32'(dma_done), 32'd0);
    exp_data.delete(); exp_addr.delete();
    @(posedge clk); #2;
    reset = 1'b0; stream_ready = 1'b1;
    d0 = n_done;
    start_xfer(16'h4000, 4);
    wait_done("post_rst", d0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
